// File: rtl/spi_to_nitta_assembler_pkg.sv
// Widths and byte-order constants shared by the SPI<->NITTA splitter and assembler,
// so that both sides agree on word size and MSB-first byte order.
package spi_to_nitta_assembler_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_SPI_DATA_WIDTH = 8;

  function automatic int bytes_per_word(input int dw, input int sw);
    return dw / sw;
  endfunction

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } asm_state_t;

endpackage

// File: rtl/spi_rise_detect.sv
// One-flop rising-edge detector on the SPI driver's ready level.
module spi_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev <= 1'b0;
    else      r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/spi_to_nitta_assembler.sv
// Packs MSB-first SPI transfer units into NITTA words held behind a valid/ack register.
// A frame reset drops the partial word; a word completing while the output is busy is lost.
module spi_to_nitta_assembler
  import spi_to_nitta_assembler_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int SPI_DATA_WIDTH = DEF_SPI_DATA_WIDTH,
  localparam int N             = bytes_per_word(DATA_WIDTH, SPI_DATA_WIDTH),
  localparam int CNT_W         = $clog2(N) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_rst,
  input  logic                      spi_ready,
  input  logic [SPI_DATA_WIDTH-1:0] from_spi,
  output logic [DATA_WIDTH-1:0]     to_nitta,
  output logic                      to_nitta_valid,
  input  logic                      to_nitta_ack,
  output logic [CNT_W-1:0]          byte_cnt,
  output logic                      overflow
);

  generate
    if ((DATA_WIDTH % SPI_DATA_WIDTH) != 0 || N < 2) begin : g_width_check
      $error("DATA_WIDTH must be a multiple (>=2x) of SPI_DATA_WIDTH");
    end
  endgenerate

  asm_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_valid;
  logic                  r_ovf;

  logic                  w_rise;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_out_free;
  logic [DATA_WIDTH-1:0] w_next_shift;

  spi_rise_detect u_rise (
    .clk     (clk),
    .rst     (rst),
    .i_level (spi_ready),
    .o_rise  (w_rise)
  );

  assign w_accept     = w_rise & ~frame_rst;
  assign w_complete   = w_accept && (r_cnt == CNT_W'(N - 1));
  assign w_out_free   = ~r_valid | to_nitta_ack;
  assign w_next_shift = {r_shift[DATA_WIDTH-SPI_DATA_WIDTH-1:0], from_spi};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (frame_rst) begin
        r_state <= S_IDLE;
        r_shift <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (w_accept) begin
            r_shift <= w_next_shift;
            r_cnt   <= CNT_W'(1);
            r_state <= S_COLLECT;
          end
          S_COLLECT: if (w_accept) begin
            r_shift <= w_next_shift;
            if (w_complete) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end

      // Output register runs independently of collection; a completion wins over ack.
      if (w_complete && w_out_free) begin
        r_out   <= w_next_shift;
        r_valid <= 1'b1;
      end else if (w_complete) begin
        r_ovf <= 1'b1;
      end else if (to_nitta_ack && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign to_nitta       = r_out;
  assign to_nitta_valid = r_valid;
  assign byte_cnt       = r_cnt;
  assign overflow       = r_ovf;

endmodule
